// File: rtl/bram_dsp_sequencer.sv
// rtl/bram_dsp_sequencer.sv - multi-element BRAM0/BRAM1 -> DSP48 -> BRAM1 command sequencer
// Streams cmd_len elements per accepted command; writes land LAT cycles after their reads issue.
module bram_dsp_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int LAT    = 4,
  parameter int WE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src_addr,
  input  logic [ADDR_W-1:0] cmd_acc_addr,
  input  logic [ADDR_W-1:0] cmd_dst_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [4:0]        cmd_inmode,
  input  logic [6:0]        cmd_opmode,
  input  logic [3:0]        cmd_alumode,
  input  logic              abort,
  output logic [ADDR_W-1:0] bram0_addr,
  output logic [ADDR_W-1:0] bram1_raddr,
  output logic [ADDR_W-1:0] bram1_waddr,
  output logic [WE_W-1:0]   bram1_we,
  output logic [4:0]        dsp_inmode,
  output logic [6:0]        dsp_opmode,
  output logic [3:0]        dsp_alumode,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  // All pipeline stages except the last one (which is the write in progress).
  localparam logic [LAT-1:0] EARLY_MASK = {LAT{1'b1}} >> 1;

  state_t            state;
  logic [LEN_W:0]    remaining;
  logic [ADDR_W-1:0] wr_ptr;
  logic [LAT-1:0]    pipe_v;
  logic [ADDR_W-1:0] pipe_a [LAT];
  logic [LAT-1:0]    v_in;
  logic [ADDR_W-1:0] a_in [LAT];
  logic              accept;
  logic              issuing;
  logic              abort_clr;

  assign cmd_ready   = (state == ST_IDLE) && !abort;
  assign accept      = cmd_valid && cmd_ready;
  assign issuing     = (state == ST_ISSUE);
  assign abort_clr   = abort && (state != ST_IDLE);
  assign bram1_we    = {WE_W{pipe_v[LAT-1]}};
  assign bram1_waddr = pipe_a[LAT-1];

  assign a_in[0] = wr_ptr;
  generate
    if (LAT == 1) begin : g_v_one
      assign v_in = issuing;
    end else begin : g_v_many
      assign v_in = {pipe_v[LAT-2:0], issuing};
    end
    for (genvar g = 1; g < LAT; g++) begin : g_a_in
      assign a_in[g] = pipe_a[g-1];
    end
  endgenerate

  // Addresses only advance alongside a valid entry so bram1_waddr holds between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
      for (int i = 0; i < LAT; i++) pipe_a[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= v_in[i] && !abort_clr;
        if (v_in[i] && !abort_clr) pipe_a[i] <= a_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      wr_ptr      <= '0;
      bram0_addr  <= '0;
      bram1_raddr <= '0;
      dsp_inmode  <= '0;
      dsp_opmode  <= '0;
      dsp_alumode <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dsp_inmode  <= cmd_inmode;
            dsp_opmode  <= cmd_opmode;
            dsp_alumode <= cmd_alumode;
            wr_ptr      <= cmd_dst_addr;
            remaining   <= {1'b0, cmd_len};
            if (cmd_len != '0) begin
              state       <= ST_ISSUE;
              busy        <= 1'b1;
              bram0_addr  <= cmd_src_addr;
              bram1_raddr <= cmd_acc_addr;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            // Read addresses stay on the last element once issue completes.
            if (remaining == (LEN_W+1)'(1)) begin
              state <= ST_DRAIN;
            end else begin
              remaining   <= remaining - (LEN_W+1)'(1);
              bram0_addr  <= bram0_addr + ADDR_W'(1);
              bram1_raddr <= bram1_raddr + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if ((pipe_v & EARLY_MASK) == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_dsp_sequencer.sv
// tb/tb_bram_dsp_sequencer.sv - scoreboard bench for bram_dsp_sequencer
// Expected reads, writes, done pulses, modes and busy are derived from cycle arithmetic on each command.
module tb_bram_dsp_sequencer;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int LAT    = 4;
  localparam int WE_W   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src_addr = '0;
  logic [ADDR_W-1:0] cmd_acc_addr = '0;
  logic [ADDR_W-1:0] cmd_dst_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [4:0]        cmd_inmode = '0;
  logic [6:0]        cmd_opmode = '0;
  logic [3:0]        cmd_alumode = '0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] bram0_addr;
  logic [ADDR_W-1:0] bram1_raddr;
  logic [ADDR_W-1:0] bram1_waddr;
  logic [WE_W-1:0]   bram1_we;
  logic [4:0]        dsp_inmode;
  logic [6:0]        dsp_opmode;
  logic [3:0]        dsp_alumode;
  logic              busy;
  logic              done;

  bram_dsp_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .LAT(LAT), .WE_W(WE_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_acc_addr(cmd_acc_addr), .cmd_dst_addr(cmd_dst_addr),
    .cmd_len(cmd_len), .cmd_inmode(cmd_inmode), .cmd_opmode(cmd_opmode),
    .cmd_alumode(cmd_alumode), .abort(abort), .bram0_addr(bram0_addr),
    .bram1_raddr(bram1_raddr), .bram1_waddr(bram1_waddr), .bram1_we(bram1_we),
    .dsp_inmode(dsp_inmode), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int                c;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
  } ev_t;

  ev_t               rq[$];
  ev_t               wq[$];
  int                dq[$];
  logic [ADDR_W-1:0] last_r0, last_r1, last_w;
  logic [15:0]       exp_mode, mode_next;
  int                mode_cyc, busy_from, busy_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic int done_cyc(input int t, input int len);
    return (len == 0) ? t + 1 : t + len + LAT + 1;
  endfunction

  task automatic model_reset();
    rq.delete(); wq.delete(); dq.delete();
    last_r0 = '0; last_r1 = '0; last_w = '0;
    exp_mode = '0; mode_next = '0; mode_cyc = -1;
    busy_from = 1; busy_to = 0;
  endtask

  task automatic model_accept(input int t, input logic [ADDR_W-1:0] src, acc, dst,
                              input logic [LEN_W-1:0] len, input logic [15:0] modes);
    mode_next = modes;
    mode_cyc  = t + 1;
    for (int k = 0; k < int'(len); k++) begin
      rq.push_back('{t + 1 + k, src + ADDR_W'(k), acc + ADDR_W'(k)});
      wq.push_back('{t + 1 + k + LAT, dst + ADDR_W'(k), '0});
    end
    dq.push_back(done_cyc(t, int'(len)));
    busy_from = t + 1;
    busy_to   = (len == 0) ? t : t + int'(len) + LAT;
  endtask

  task automatic model_abort(input int a);
    while (rq.size() > 0 && rq[$].c > a) void'(rq.pop_back());
    while (wq.size() > 0 && wq[$].c > a) void'(wq.pop_back());
    while (dq.size() > 0 && dq[$] > a) void'(dq.pop_back());
    if (busy_to > a) busy_to = a;
  endtask

  // Monitor: samples on the falling edge, pops expectations as the DUT presents results.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (cyc == mode_cyc) exp_mode = mode_next;
      check("dsp_mode", 32'({dsp_inmode, dsp_opmode, dsp_alumode}), 32'(exp_mode));

      if (rq.size() > 0 && rq[0].c == cyc) begin
        last_r0 = rq[0].a;
        last_r1 = rq[0].b;
        void'(rq.pop_front());
      end
      check("bram0_addr", 32'(bram0_addr), 32'(last_r0));
      check("bram1_raddr", 32'(bram1_raddr), 32'(last_r1));

      while (wq.size() > 0 && wq[0].c < cyc) begin
        flag("write_missing");
        void'(wq.pop_front());
      end
      if (bram1_we != '0) begin
        if (wq.size() == 0) begin
          flag("write_unexpected");
        end else begin
          check("write_cycle", 32'(cyc), 32'(wq[0].c));
          check("bram1_we", 32'(bram1_we), 32'({WE_W{1'b1}}));
          last_w = wq[0].a;
          void'(wq.pop_front());
        end
      end
      check("bram1_waddr", 32'(bram1_waddr), 32'(last_w));

      while (dq.size() > 0 && dq[0] < cyc) begin
        flag("done_missing");
        void'(dq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) flag("done_unexpected");
        else begin
          check("done_cycle", 32'(cyc), 32'(dq[0]));
          void'(dq.pop_front());
        end
      end

      check("busy", 32'(busy), 32'((cyc >= busy_from && cyc <= busy_to) ? 1 : 0));
    end
  end

  task automatic wait_cycle(input int c);
    while (1) begin
      @(negedge clk);
      if (cyc >= c) break;
    end
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] src, acc, dst, input logic [LEN_W-1:0] len,
                       input logic [15:0] modes, input bit hold, output int t);
    t = -1;
    for (int w = 0; w < 1000 && t < 0; w++) begin
      @(negedge clk); #1;
      cmd_valid    = 1'b1;
      cmd_src_addr = src;
      cmd_acc_addr = acc;
      cmd_dst_addr = dst;
      cmd_len      = len;
      {cmd_inmode, cmd_opmode, cmd_alumode} = modes;
      #1;
      if (cmd_ready) begin
        t = cyc;
        model_accept(t, src, acc, dst, len, modes);
      end
    end
    if (t < 0) flag("accept_timeout");
    if (!hold) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic abort_at(input int a);
    wait_cycle(a);
    abort = 1'b1;
    model_abort(a);
    @(negedge clk); #1;
    abort = 1'b0;
    #1;
    check("ready_after_abort", 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_we"}, 32'(bram1_we), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_addrs"}, 32'({bram0_addr, bram1_raddr, bram1_waddr}), 32'd0);
    check({name, "_modes"}, 32'({dsp_inmode, dsp_opmode, dsp_alumode}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, a;
    logic [ADDR_W-1:0] s, r, d;
    logic [LEN_W-1:0]  l;
    logic [15:0]       m;

    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("in_reset");
    reset = 1'b1;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Basic three-element command
    issue(10'h010, 10'h020, 10'h030, 8'd3, 16'h1234, 1'b0, t);
    wait_cycle(t + 8);
    check("ready_in_done", 32'(cmd_ready), 32'd0);
    wait_cycle(t + 9);
    check("ready_after_done", 32'(cmd_ready), 32'd1);

    // Zero-length no-op
    issue(10'h100, 10'h200, 10'h300, 8'd0, 16'hBEEF, 1'b0, t);
    wait_cycle(t + 2);

    // Address wrap
    issue(10'h3FE, 10'h3FD, 10'h3FF, 8'd3, 16'h0F0F, 1'b0, t);
    wait_cycle(done_cyc(t, 3));

    // Abort mid-issue, then a normal command
    issue(10'h040, 10'h050, 10'h060, 8'd8, 16'h5A5A, 1'b0, t);
    abort_at(t + 3);
    issue(10'h070, 10'h080, 10'h090, 8'd2, 16'hA5A5, 1'b0, t);
    wait_cycle(done_cyc(t, 2));

    // Asynchronous reset mid-command
    issue(10'h111, 10'h222, 10'h333, 8'd4, 16'h7777, 1'b0, t);
    wait_cycle(t + 6);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("ready_after_mid_reset", 32'(cmd_ready), 32'd1);

    // cmd_valid held through busy with changing fields
    issue(10'h00A, 10'h00B, 10'h00C, 8'd5, 16'h1111, 1'b1, t);
    issue(10'h20A, 10'h20B, 10'h20C, 8'd2, 16'h2222, 1'b0, t2);
    check("b2b_accept_cycle", 32'(t2), 32'(t + 5 + LAT + 2));
    wait_cycle(done_cyc(t2, 2));

    // Randomized commands with occasional aborts
    for (int n = 0; n < 30; n++) begin
      s = ADDR_W'($urandom);
      r = ADDR_W'($urandom);
      d = ADDR_W'($urandom);
      l = LEN_W'($urandom_range(0, 12));
      m = 16'($urandom);
      issue(s, r, d, l, m, 1'b0, t);
      if (l != 0 && $urandom_range(0, 3) == 0) begin
        a = t + int'($urandom_range(1, int'(l) + LAT));
        abort_at(a);
      end else begin
        wait_cycle(done_cyc(t, int'(l)) + int'($urandom_range(0, 2)));
      end
    end

    // Maximum length
    issue(10'h3F0, 10'h005, 10'h3FA, 8'd255, 16'hC3C3, 1'b0, t);
    wait_cycle(done_cyc(t, 255) + 3);

    check("queues_drained", 32'(rq.size() + wq.size() + dq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_dsp_sequencer.md
Name: bram_dsp_sequencer

Overview:
Parametrised, multi-element successor to the single-shot BRAM/DSP controller. It accepts one command per handshake and streams LEN elements:
- reads operand A from BRAM0 and operand B from BRAM1 at consecutive addresses;
- holds the DSP mode fields stable for the whole command;
- writes each DSP result back into BRAM1 at consecutive destination addresses, after a fixed pipeline latency.

It sits between the host instruction path and the BRAM0/BRAM1/DSP48 datapath.

Parameters:
ADDR_W, 10, BRAM address width; all address arithmetic is modulo 2^ADDR_W.
LEN_W, 8, width of the element-count field.
LAT, 4, cycles from issue of an element's read addresses to its BRAM1 write; legal range 1..15.
WE_W, 4, BRAM1 byte-write-enable width.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  high only in IDLE; accept = cmd_valid & cmd_ready.
cmd_src_addr  input  ADDR_W  BRAM0 start read address.
cmd_acc_addr  input  ADDR_W  BRAM1 start read address.
cmd_dst_addr  input  ADDR_W  BRAM1 start write address.
cmd_len  input  LEN_W  element count; 0 = no-op.
cmd_inmode  input  5  DSP INMODE for this command.
cmd_opmode  input  7  DSP OPMODE for this command.
cmd_alumode  input  4  DSP ALUMODE for this command.
abort  input  1  synchronous cancel.
bram0_addr  output  ADDR_W  BRAM0 read address.
bram1_raddr  output  ADDR_W  BRAM1 read address.
bram1_waddr  output  ADDR_W  BRAM1 write address.
bram1_we  output  WE_W  BRAM1 write enable; all ones or all zeros.
dsp_inmode  output  5  registered DSP mode.
dsp_opmode  output  7  registered DSP mode.
dsp_alumode  output  4  registered DSP mode.
busy  output  1  high in ISSUE and DRAIN.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE;
  - all address outputs, mode outputs, counters, pipeline valids, bram1_we, busy and done = 0;
  - cmd_ready = 1 once reset is released.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - on accept in cycle T, latch all cmd fields;
  - dsp_* outputs take the new modes from cycle T+1 and hold them until the next accept;
  - next state is ISSUE if cmd_len != 0, else DONE.
- ISSUE:
  - for k = 0..LEN-1, in cycle T+1+k: bram0_addr = src+k and bram1_raddr = acc+k (mod 2^ADDR_W);
  - each issue pushes {valid, dst+k} into a LAT-deep shift pipeline;
  - after k = LEN-1, go to DRAIN.
- Writes:
  - element k is written in cycle T+1+k+LAT, with bram1_we = all ones and bram1_waddr = dst+k;
  - bram1_we = 0 in every other cycle;
  - bram1_waddr holds its last value when bram1_we = 0.
- DRAIN: wait until the pipeline is empty, then go to DONE.
  - The last write occurs in cycle T+LEN+LAT.
  - done = 1 in cycle T+LEN+LAT+1 (DONE state).
  - For LEN = 0, done = 1 in cycle T+1 and no write occurs.
- DONE: lasts exactly one cycle, then IDLE.
- Outside ISSUE, bram0_addr and bram1_raddr hold their last value.
- Back-to-back commands:
  - a new command may be accepted in the cycle after DONE;
  - there is no overlap between commands.
- Address wrap: the read and write counters wrap modulo 2^ADDR_W with no error flag.
- Read/write overlap: BRAM1 reads and writes use separate ports and may target the same address in the same cycle. BRAM read-during-write semantics are the memory's responsibility; the sequencer does not stall.
- cmd_len at maximum: the element counter is LEN_W+1 bits wide, so cmd_len = 2^LEN_W-1 completes with no overflow.
- abort (synchronous, any non-IDLE state):
  - next cycle: state = IDLE, all pipeline valids cleared, bram1_we = 0;
  - no done pulse;
  - dsp_* outputs hold their values;
  - abort in IDLE is ignored, and abort takes priority over accept.
- cmd_valid while busy: ignored, because cmd_ready = 0; the fields are not sampled.
- Reset mid-command: outputs return immediately (asynchronously) to reset values; no write completes.

Test Plan:
1. Reset, then accept src=0x010, acc=0x020, dst=0x030, len=3, LAT=4 at T → bram0_addr=0x010/0x011/0x012 at T+1..T+3; bram1_we=0xF with waddr 0x030/0x031/0x032 at T+5..T+7; done=1 only at T+8; cmd_ready high again at T+9.
2. len=0 → done at T+1, bram1_we never asserted, busy never high.
3. src=0x3FE, dst=0x3FF, len=3 → read addresses 0x3FE, 0x3FF, 0x000; write addresses 0x3FF, 0x000, 0x001.
4. abort asserted at T+3 of a len=8 command → bram1_we=0 from T+4 onward, no done pulse, cmd_ready=1 at T+4; a following command then runs correctly.
5. reset driven low at T+6 of a len=4 command → bram1_we, busy and all addresses go to 0 immediately; after release, state is IDLE and cmd_ready=1.
6. cmd_valid held high throughout with differing fields while busy → only the first command executes; the second is accepted in the cycle after done, with dsp_opmode changing only at that accept+1.
